// File: rtl/race_response_fifo.sv
// Response collector for the RO-PUF datapath: assembles winner bits into words and
// queues them in a first-word-fall-through FIFO drained over valid/ready.
module race_response_fifo #(
    parameter int RESP_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter bit LSB_FIRST  = 1'b0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            winner,
    input  logic                            done,
    output logic [RESP_WIDTH-1:0]           resp_data,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic [$clog2(RESP_WIDTH+1)-1:0] bit_count,
    output logic [$clog2(DEPTH+1)-1:0]      level,
    output logic                            full,
    output logic                            overflow
);

    localparam int CW = $clog2(RESP_WIDTH + 1);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(RESP_WIDTH - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [RESP_WIDTH-1:0] shreg_q, shreg_d, shifted;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  ovf_q, ovf_d;
    logic [RESP_WIDTH-1:0] mem_q [DEPTH];

    logic pop, complete, push_ok, drop, empty;

    assign empty    = (level_q == '0);
    assign pop      = !empty && resp_ready && !clear;
    assign complete = done && (cnt_q == CNT_LAST) && !clear;
    // A push into a full FIFO is still legal when a pop frees the head slot on the same edge.
    assign push_ok  = complete && ((level_q != LVL_FULL) || pop);
    assign drop     = complete && (level_q == LVL_FULL) && !pop;

    always_comb begin
        if (LSB_FIRST) begin
            shifted = {winner, shreg_q[RESP_WIDTH-1:1]};
        end else begin
            shifted = {shreg_q[RESP_WIDTH-2:0], winner};
        end
    end

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        if (clear) begin
            shreg_d = '0;
            cnt_d   = '0;
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (done) begin
                if (complete) begin
                    shreg_d = '0;
                    cnt_d   = '0;
                end else begin
                    shreg_d = shifted;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            if (push_ok) begin
                wptr_d = wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            if (push_ok && !pop) begin
                level_d = level_q + LW'(1);
            end else if (pop && !push_ok) begin
                level_d = level_q - LW'(1);
            end
            if (drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage needs no reset: the head is masked whenever level is zero.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= shifted;
        end
    end

    assign resp_data  = empty ? '0 : mem_q[rptr_q];
    assign resp_valid = !empty;
    assign bit_count  = cnt_q;
    assign level      = level_q;
    assign full       = (level_q == LVL_FULL);
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_race_response_fifo.sv
// Scoreboard bench for race_response_fifo: MSB-first main instance plus an LSB-first
// instance sharing the same stimulus.
module tb_race_response_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic       winner = 1'b0;
    logic       done = 1'b0;
    logic       resp_ready = 1'b0;

    logic [7:0] resp_data, l_resp_data;
    logic       resp_valid, l_resp_valid;
    logic [3:0] bit_count, l_bit_count;
    logic [2:0] level, l_level;
    logic       full, l_full;
    logic       overflow, l_overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    race_response_fifo #(.RESP_WIDTH(8), .DEPTH(4), .LSB_FIRST(1'b0)) dut (
        .clk(clk), .rst(rst), .clear(clear), .winner(winner), .done(done),
        .resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .bit_count(bit_count), .level(level), .full(full), .overflow(overflow)
    );

    race_response_fifo #(.RESP_WIDTH(8), .DEPTH(4), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .rst(rst), .clear(clear), .winner(winner), .done(done),
        .resp_data(l_resp_data), .resp_valid(l_resp_valid), .resp_ready(resp_ready),
        .bit_count(l_bit_count), .level(l_level), .full(l_full), .overflow(l_overflow)
    );

    // Sends one word MSB-first on consecutive done pulses; ends at the negedge after the last edge.
    task automatic send_word(input logic [7:0] val);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            winner = val[7-i];
            done   = 1'b1;
        end
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic send_bits(input int n, input logic [7:0] val);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            winner = val[7-i];
            done   = 1'b1;
        end
        @(negedge clk);
        done = 1'b0;
    endtask

    // Drains the main instance against the scoreboard, starting at a negedge.
    task automatic drain(input string tag);
        resp_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (exp_q.size() == 0) break;
            n_checks++;
            if (resp_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_valid: got %b want 1 (%0d words left)", tag, resp_valid, exp_q.size());
                exp_q.delete();
                break;
            end
            n_checks++;
            if (resp_data !== exp_q[0]) begin
                n_fail++;
                $display("FAIL %s_data: got %h want %h", tag, resp_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
            @(negedge clk);
        end
        resp_ready = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0 || resp_data !== 8'h00) begin
            n_fail++;
            $display("FAIL %s_empty: got valid=%b data=%h want 0/00", tag, resp_valid, resp_data);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #12;
        n_checks++;
        if ({resp_valid, resp_data, bit_count, level, full, overflow} !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_main: got v=%b d=%h bc=%0d lv=%0d f=%b o=%b want all 0",
                     resp_valid, resp_data, bit_count, level, full, overflow);
        end
        n_checks++;
        if ({l_resp_valid, l_resp_data, l_bit_count, l_level, l_full, l_overflow} !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_lsb: got v=%b d=%h want all 0", l_resp_valid, l_resp_data);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_bit_order;
        send_word(8'hB2);
        exp_q.push_back(8'hB2);
        n_checks++;
        if (resp_valid !== 1'b1 || resp_data !== 8'hB2 || level !== 3'd1 || bit_count !== 4'd0) begin
            n_fail++;
            $display("FAIL msb_first: got v=%b d=%h lv=%0d bc=%0d want 1/b2/1/0",
                     resp_valid, resp_data, level, bit_count);
        end
        n_checks++;
        if (l_resp_valid !== 1'b1 || l_resp_data !== 8'h4D) begin
            n_fail++;
            $display("FAIL lsb_first: got v=%b d=%h want 1/4d", l_resp_valid, l_resp_data);
        end
        drain("order");
    endtask

    task automatic test_overflow;
        for (int w = 1; w <= 4; w++) begin
            send_word(8'(w));
            exp_q.push_back(8'(w));
        end
        n_checks++;
        if (full !== 1'b1 || level !== 3'd4 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_full: got f=%b lv=%0d o=%b want 1/4/0", full, level, overflow);
        end
        send_word(8'h05);
        n_checks++;
        if (overflow !== 1'b1 || level !== 3'd4 || bit_count !== 4'd0) begin
            n_fail++;
            $display("FAIL ovf_drop: got o=%b lv=%0d bc=%0d want 1/4/0", overflow, level, bit_count);
        end
        drain("ovf");
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %b want 1", overflow);
        end
    endtask

    task automatic test_simul_push_pop;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_checks++;
        if (overflow !== 1'b0 || level !== 3'd0) begin
            n_fail++;
            $display("FAIL clear_ovf: got o=%b lv=%0d want 0/0", overflow, level);
        end
        for (int w = 0; w < 4; w++) begin
            send_word(8'h11 + 8'(w));
            exp_q.push_back(8'h11 + 8'(w));
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            winner = 8'h15 >> (7 - i);
            done   = 1'b1;
            if (i == 7) begin
                resp_ready = 1'b1;
                n_checks++;
                if (resp_data !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL simul_head: got %h want %h", resp_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
        exp_q.push_back(8'h15);
        @(negedge clk);
        done = 1'b0;
        n_checks++;
        if (level !== 3'd4 || overflow !== 1'b0 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_level: got lv=%0d o=%b f=%b want 4/0/1", level, overflow, full);
        end
        drain("simul");
    endtask

    task automatic test_clear_midword;
        send_word(8'h21);
        send_word(8'h22);
        send_bits(3, 8'hE0);
        n_checks++;
        if (bit_count !== 4'd3 || level !== 3'd2) begin
            n_fail++;
            $display("FAIL pre_clear: got bc=%0d lv=%0d want 3/2", bit_count, level);
        end
        @(negedge clk);
        clear = 1'b1;
        done = 1'b1;
        winner = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        done = 1'b0;
        resp_ready = 1'b0;
        n_checks++;
        if (bit_count !== 4'd0 || level !== 3'd0 || resp_valid !== 1'b0 || overflow !== 1'b0
            || resp_data !== 8'h00) begin
            n_fail++;
            $display("FAIL clear_flush: got bc=%0d lv=%0d v=%b o=%b d=%h want all 0",
                     bit_count, level, resp_valid, overflow, resp_data);
        end
        send_word(8'hF0);
        exp_q.push_back(8'hF0);
        n_checks++;
        if (resp_data !== 8'hF0 || level !== 3'd1) begin
            n_fail++;
            $display("FAIL post_clear: got d=%h lv=%0d want f0/1", resp_data, level);
        end
        drain("clear");
    endtask

    task automatic test_async_reset;
        send_word(8'h33);
        send_bits(5, 8'hA8);
        n_checks++;
        if (bit_count !== 4'd5 || level !== 3'd1) begin
            n_fail++;
            $display("FAIL pre_rst: got bc=%0d lv=%0d want 5/1", bit_count, level);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({resp_valid, resp_data, bit_count, level, full, overflow} !== 17'h0) begin
            n_fail++;
            $display("FAIL async_rst: got v=%b d=%h bc=%0d lv=%0d want all 0",
                     resp_valid, resp_data, bit_count, level);
        end
        @(negedge clk);
        rst = 1'b1;
        send_word(8'h5A);
        exp_q.push_back(8'h5A);
        n_checks++;
        if (resp_data !== 8'h5A || level !== 3'd1 || bit_count !== 4'd0) begin
            n_fail++;
            $display("FAIL post_rst: got d=%h lv=%0d bc=%0d want 5a/1/0", resp_data, level, bit_count);
        end
        drain("rst");
    endtask

    initial begin
        test_reset();
        test_bit_order();
        test_overflow();
        test_simul_push_pop();
        test_clear_midword();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
